i2c_target: RTL

- I2C target (slave) endpoint. It responds to one fixed 7-bit address and completes the master side of the team's two-wire I2C link.
- Both lines are oversampled on the system clock. START/STOP, address and R/W are decoded; the target ACKs only on an address match.
- Write payload bytes are delivered on a valid strobe. Read payload bytes are taken from the user and shifted onto SDA.
- SDA is driven open-drain through the existing io_pad: the target only ever pulls low or releases.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_target_if.sv | 21 ++
 rtl/i2c_line_sync.sv | 47 ++++
 rtl/io_pad.sv | 11 +
 rtl/i2c_target.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C target: FSM states, ACK/NACK levels and the
// meaning of the R/W bit that follows the address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// User-side payload handshake of the I2C target: read data in, write data out,
// and the busy flag. The slave modport is the target's view.
interface i2c_target_if #(
  parameter int DATA_BW = 8
);
  logic [DATA_BW-1:0] i_tx_data;
  logic               o_tx_req;
  logic [DATA_BW-1:0] o_rx_data;
  logic               o_rx_valid;
  logic               o_busy;

  modport slave (
    input  i_tx_data,
    output o_tx_req, o_rx_data, o_rx_valid, o_busy
  );

  modport master (
    output i_tx_data,
    input  o_tx_req, o_rx_data, o_rx_valid, o_busy
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL and SDA into the system clock and derives SCL edges and
// START/STOP conditions from each line's synced level and one history flop.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic scl_pad,
  input  logic sda_pad,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] pad_in;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;

  assign pad_in = {sda_pad, scl_pad};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_line
      // [1:0] synchroniser, [2] history; reset to the idle-bus level
      logic [2:0] pipe_reg;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          pipe_reg <= '1;
        end else begin
          pipe_reg <= {pipe_reg[1:0], pad_in[gi]};
        end
      end

      assign level[gi] = pipe_reg[1];
      assign rise[gi]  = pipe_reg[1] & ~pipe_reg[2];
      assign fall[gi]  = ~pipe_reg[1] & pipe_reg[2];
    end
  endgenerate

  assign sda       = level[1];
  assign scl_rise  = rise[0];
  assign scl_fall  = fall[0];
  // SDA moving while SCL is high is a bus condition, never data
  assign start_det = fall[1] & level[0];
  assign stop_det  = rise[1] & level[0];
endmodule

// File: rtl/io_pad.sv
// Bidirectional pad: drives tx_data when tx_en is set, otherwise floats.
// With tx_data tied low it behaves as an open-drain output.
module io_pad (
  input  logic tx_data,
  input  logic tx_en,
  output logic rx_data,
  inout  wire  pad
);
  assign pad     = tx_en ? tx_data : 1'bz;
  assign rx_data = pad;
endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: decodes START/STOP, matches one fixed address, delivers
// written bytes on a strobe and shifts user-supplied bytes out on reads.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int                 ADDR_BW     = 7,
  parameter int                 DATA_BW     = 8,
  parameter logic [ADDR_BW-1:0] TARGET_ADDR = 7'h42
) (
  input  logic        i_clk,
  input  logic        i_rst,
  i2c_target_if.slave usr,
  input  logic        i2c_scl,
  inout  wire         i2c_sda
);
  localparam int                CNT_BW  = $clog2(DATA_BW);
  localparam logic [CNT_BW-1:0] CNT_TOP = CNT_BW'(DATA_BW - 1);

  logic sda_pad, sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e           state_reg, state_next;
  logic [CNT_BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DATA_BW-2:0]   shift_reg, shift_next;
  logic [DATA_BW-2:0]   tx_shift_reg, tx_shift_next;
  logic                 rw_reg, rw_next;
  logic                 phase_reg, phase_next;
  logic                 pull_reg, pull_next;
  logic                 busy_reg, busy_next;
  logic [DATA_BW-1:0]   rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 tx_req_reg, tx_req_next;
  logic [DATA_BW-1:0]   rx_byte;

  i2c_line_sync u_line_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .scl_pad   (i2c_scl),
    .sda_pad   (sda_pad),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  io_pad u_sda_pad (
    .tx_data (1'b0),
    .tx_en   (pull_reg),
    .rx_data (sda_pad),
    .pad     (i2c_sda)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= CNT_TOP;
      shift_reg    <= '0;
      tx_shift_reg <= '0;
      rw_reg       <= RW_WRITE;
      phase_reg    <= 1'b0;
      pull_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      tx_req_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_shift_reg <= tx_shift_next;
      rw_reg       <= rw_next;
      phase_reg    <= phase_next;
      pull_reg     <= pull_next;
      busy_reg     <= busy_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      tx_req_reg   <= tx_req_next;
    end
  end

  // phase_reg marks the second half of a two-fall ACK slot, or a master ACK seen
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_shift_next = tx_shift_reg;
    rw_next       = rw_reg;
    phase_next    = phase_reg;
    pull_next     = pull_reg;
    busy_next     = busy_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_req_next   = 1'b0;
    rx_byte       = {shift_reg, sda};

    if (start_det || stop_det) begin
      state_next   = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_next = CNT_TOP;
      phase_next   = 1'b0;
      pull_next    = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR, ST_WRITE: begin
          if (scl_rise) begin
            shift_next = rx_byte[DATA_BW-2:0];
            if (bit_cnt_reg == '0) begin
              bit_cnt_next = CNT_TOP;
              phase_next   = 1'b0;
              if (state_reg == ST_WRITE) begin
                rx_data_next  = rx_byte;
                rx_valid_next = 1'b1;
                state_next    = ST_WRITE_ACK;
              end else begin
                rw_next    = sda;
                state_next = (rx_byte[DATA_BW-1 -: ADDR_BW] == TARGET_ADDR) ?
                             ST_ADDR_ACK : ST_IGNORE;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg - CNT_BW'(1);
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              pull_next  = 1'b1;
              busy_next  = 1'b1;
              phase_next = 1'b1;
            end else begin
              phase_next   = 1'b0;
              bit_cnt_next = CNT_TOP;
              if (rw_reg == RW_READ) begin
                tx_shift_next = usr.i_tx_data[DATA_BW-2:0];
                tx_req_next   = 1'b1;
                pull_next     = ~usr.i_tx_data[DATA_BW-1];
                state_next    = ST_READ;
              end else begin
                pull_next  = 1'b0;
                state_next = ST_WRITE;
              end
            end
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            pull_next  = ~phase_reg;
            phase_next = ~phase_reg;
            if (phase_reg) state_next = ST_WRITE;
          end
        end
        ST_READ: begin
          if (scl_fall) begin
            if (bit_cnt_reg == '0) begin
              pull_next  = 1'b0;
              phase_next = 1'b0;
              state_next = ST_READ_ACK;
            end else begin
              pull_next     = ~tx_shift_reg[DATA_BW-2];
              tx_shift_next = {tx_shift_reg[DATA_BW-3:0], 1'b0};
              bit_cnt_next  = bit_cnt_reg - CNT_BW'(1);
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda == ACK) begin
              phase_next = 1'b1;
            end else begin
              busy_next  = 1'b0;
              state_next = ST_IGNORE;
            end
          end else if (scl_fall && phase_reg) begin
            phase_next    = 1'b0;
            bit_cnt_next  = CNT_TOP;
            tx_shift_next = usr.i_tx_data[DATA_BW-2:0];
            tx_req_next   = 1'b1;
            pull_next     = ~usr.i_tx_data[DATA_BW-1];
            state_next    = ST_READ;
          end
        end
        default: begin
          pull_next = 1'b0;
        end
      endcase
    end
  end

  assign usr.o_rx_data  = rx_data_reg;
  assign usr.o_rx_valid = rx_valid_reg;
  assign usr.o_tx_req   = tx_req_reg;
  assign usr.o_busy     = busy_reg;
endmodule
